// File: rtl/ls_writeback.sv
// Writeback/forwarding stage behind the local store: delays result packets DEPTH stages,
// commits them to a 128x128 register file, and bypasses in-flight results to three read ports.
module ls_writeback #(
  parameter int DEPTH = 2,
  parameter int NREG  = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:138] FWpipe6,
  input  logic         flush,
  input  logic [0:6]   addr_ra,
  input  logic [0:6]   addr_rb,
  input  logic [0:6]   addr_rc,
  output logic [0:127] ra,
  output logic [0:127] rb,
  output logic [0:127] rc,
  output logic         commit_wr,
  output logic [0:6]   commit_addr
);

  logic [0:127] w_in_data;
  logic [0:2]   w_in_tag;
  logic         w_in_wr;
  logic [0:6]   w_in_addr;

  assign w_in_data = FWpipe6[0:127];
  assign w_in_tag  = FWpipe6[128:130];
  assign w_in_wr   = FWpipe6[131];
  assign w_in_addr = FWpipe6[132:138];

  logic [DEPTH:1]         r_vld_pipe;
  logic [DEPTH:1][0:127]  r_data;
  logic [DEPTH:1][0:6]    r_addr;
  logic [DEPTH:1][0:2]    r_tag;
  logic [0:127]           r_rf [NREG];
  logic                   r_commit_wr;
  logic [0:6]             r_commit_addr;

  // The unit tag rides along for downstream debug visibility only.
  logic w_unused_tag;
  assign w_unused_tag = ^r_tag[DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_data     <= '0;
      r_addr     <= '0;
      r_tag      <= '0;
    end else begin
      r_vld_pipe[1] <= w_in_wr & ~flush;
      r_data[1]     <= w_in_data;
      r_addr[1]     <= w_in_addr;
      r_tag[1]      <= w_in_tag;
      for (int k = 2; k <= DEPTH; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1] & ~flush;
        r_data[k]     <= r_data[k-1];
        r_addr[k]     <= r_addr[k-1];
        r_tag[k]      <= r_tag[k-1];
      end
    end
  end

  // Commit from the last stage is not subject to flush: it is already architectural.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (r_vld_pipe[DEPTH]) begin
      r_rf[r_addr[DEPTH]] <= r_data[DEPTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_commit_wr   <= 1'b0;
      r_commit_addr <= '0;
    end else begin
      r_commit_wr <= r_vld_pipe[DEPTH];
      if (r_vld_pipe[DEPTH]) r_commit_addr <= r_addr[DEPTH];
    end
  end

  assign commit_wr   = r_commit_wr;
  assign commit_addr = r_commit_addr;

  logic [0:6] w_raddr [3];
  assign w_raddr[0] = addr_ra;
  assign w_raddr[1] = addr_rb;
  assign w_raddr[2] = addr_rc;

  // Walk oldest to youngest so the youngest match overrides; live input beats every stage.
  for (genvar p = 0; p < 3; p++) begin : g_port
    logic [0:127] w_rd;
    always_comb begin
      w_rd = r_rf[w_raddr[p]];
      for (int k = DEPTH; k >= 1; k--) begin
        if (r_vld_pipe[k] && (r_addr[k] == w_raddr[p])) w_rd = r_data[k];
      end
      if (w_in_wr && !flush && (w_in_addr == w_raddr[p])) w_rd = w_in_data;
    end
  end

  assign ra = g_port[0].w_rd;
  assign rb = g_port[1].w_rd;
  assign rc = g_port[2].w_rd;

endmodule

// File: doc/ls_writeback.md
# ls_writeback

Writeback and forwarding stage directly downstream of the local store unit. Consumes the 139-bit `FWpipe6` result packet and delays it through `DEPTH` forwarding stages. Commits it into the 128 × 128-bit register file. Serves three combinational operand read ports with youngest-first bypass, so the issue stage sees in-flight results.

## Interface
- `DEPTH`, 2: forwarding stages between `FWpipe6` capture and register-file commit (legal 1–6).
- `NREG`, 128: register file entries; address width fixed at 7.
- `clk  in  1`: single clock, rising edge.
- `reset  in  1`: asynchronous, active-low reset (0 = reset asserted).
- `FWpipe6  in  [0:138]`: result packet. Fields: `[0:127]` data; `[128:130]` unit tag, carried but not used; `[131]` write enable; `[132:138]` target register.
- `flush  in  1`: kills all uncommitted packets.
- `addr_ra`, `addr_rb`, `addr_rc`  in  `[0:6]`: operand read addresses.
- `ra`, `rb`, `rc`  out  `[0:127]`: operand read data, combinational.
- `commit_wr  out  1`: registered; 1 in the cycle after a register-file write.
- `commit_addr  out  [0:6]`: registered; address of that write.

## Operation
- Pipe stage k (1..`DEPTH`) holds:
  - valid: `FWpipe6[131]` as captured.
  - data: 128 bits.
  - addr: 7 bits.
  - tag: 3 bits.
- Each edge:
  - stage1 ← `FWpipe6`.
  - stage k ← stage k-1.
  - If stage `DEPTH` is valid, `RF[stage DEPTH addr]` ← its data.
- Invalid packets (`[131]`=0) shift through the pipe but never write or forward.
- Read mux, per port, highest priority first:
  - live `FWpipe6`, if `[131]`=1 and its addr matches;
  - stage1 … stage `DEPTH`, youngest first, valid and addr match;
  - RF.
- Same-address packets in several stages: the youngest wins.
- `flush`=1 at an edge:
  - stage `DEPTH`'s commit still happens; it is at the commit point.
  - All stages load invalid; the live `FWpipe6` is discarded.
  - While `flush` is high, the live `FWpipe6` does not forward.
  - Pipe-stage forwarding is unaffected until the edge.
- Reset (`reset`=0, asynchronous):
  - all RF entries = 0;
  - all stage valid = 0, data = 0;
  - `commit_wr` = 0, `commit_addr` = 0.
  - `ra`/`rb`/`rc` therefore read 0 for every address.
- Reset asserted mid-operation drops all in-flight packets immediately; no partial commit.
- All addresses 0–127 are ordinary registers; there is no hardwired-zero register.

## Timing
- Packet valid on `FWpipe6` in cycle n:
  - forwardable in cycle n, from the live input;
  - in stage k during cycles n+1 … n+`DEPTH`;
  - written to RF at the edge ending cycle n+`DEPTH`;
  - readable from RF from cycle n+`DEPTH`+1.
- `commit_wr`/`commit_addr` are high/valid in cycle n+`DEPTH`+1.
- A packet is visible on the read ports from cycle n onward with no gap. Bypass windows and RF visibility abut exactly.
- Back-to-back packets every cycle are supported; throughput is 1 per cycle with no stall.
- Read ports are purely combinational from the address inputs, `FWpipe6`, `flush`, and state. They do not depend on a clock edge.

## Test plan
- Reset, then read `addr_ra`=0, `addr_rb`=127, `addr_rc`=64 → all ports 0. Release reset; the first packet is accepted on the next edge.
- Packet addr 5, data 0x3727C5AC_612D78EC_501502F9_00000000, wr=1 in cycle n, `addr_ra`=5 held → `ra` equals that data in cycles n through n+`DEPTH`+3 with no gap. `commit_wr`=1, `commit_addr`=5 in cycle n+`DEPTH`+1.
- Packets to addr 9 on three consecutive cycles with data 1, 2, 3, `addr_rb`=9 → `rb` = 1, 2, 3 in the corresponding cycles, then stays 3. RF[9] = 3 after the final commit.
- Packet with `[131]`=0, addr 7, data all-ones → `rc` at addr 7 stays 0 throughout; `commit_wr` never asserts.
- With `DEPTH`=2: packets to addr 1 (cycle n) and addr 2 (cycle n+1), `flush`=1 in cycle n+2 → addr 1 commits (`commit_wr`=1 in cycle n+3); addr 2 never commits and reads 0 after cycle n+2.
- Assert `reset` asynchronously mid-cycle with 2 valid packets in flight → outputs go to 0 without waiting for a clock edge. After release, RF reads 0 at those addresses.
